// File: rtl/ma_pkg.sv
// Shared types and sizing for the moving-average interpolator.
// MA_INTERP_ROUND_EN selects round-half-up with saturation instead of truncation.
package ma_pkg;

    localparam int unsigned N         = 16;
    localparam int unsigned R         = 4;
    localparam int unsigned TAPS      = 16;
    localparam int unsigned TAPS_LOG2 = $clog2(TAPS);
    localparam int unsigned PHASE_W   = $clog2(R);
    localparam int unsigned PTR_W     = TAPS_LOG2;
    localparam int unsigned SUM_W     = N + TAPS_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Scale the running sum back to sample width.
    function automatic logic [N-1:0] scale_sum(input logic [SUM_W-1:0] sum);
`ifdef MA_INTERP_ROUND_EN
        logic [SUM_W:0] rnd;
        rnd = (SUM_W+1)'(sum) + (SUM_W+1)'(TAPS / 2);
        rnd = rnd >> TAPS_LOG2;
        if (rnd > (SUM_W+1)'((1 << N) - 1)) begin
            return {N{1'b1}};
        end
        return N'(rnd);
`else
        return N'(sum >> TAPS_LOG2);
`endif
    endfunction

endpackage

// File: rtl/ma_interpolator_if.sv
// Sample-in / beat-out valid/ready bundle for the interpolator.
interface ma_interpolator_if;
    import ma_pkg::*;

    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/ma_delay_line.sv
// Circular TAPS x N history buffer; exposes the oldest entry at the write pointer.
module ma_delay_line
    import ma_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_we,
    input  logic [N-1:0] i_wdata,
    output logic [N-1:0] o_oldest_c
);

    logic [N-1:0]     r_mem [TAPS];
    logic [PTR_W-1:0] r_ptr;

    assign o_oldest_c = r_mem[r_ptr];

    // Pointer wraps naturally because TAPS is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[r_ptr] <= i_wdata;
            r_ptr        <= r_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/ma_interpolator.sv
// Zero-order-hold upsampler by R followed by a recursive TAPS-point moving average.
// Build with MA_INTERP_ROUND_EN for rounded, saturated output.
module ma_interpolator
    import ma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    ma_interpolator_if.slave  bus
);

    state_e             r_state, w_state_nx;
    logic [PHASE_W-1:0] r_phase, w_phase_nx;
    logic [N-1:0]       r_hold, w_hold_nx;
    logic [SUM_W-1:0]   r_sum, w_sum_nx;
    logic [N-1:0]       r_out_data, w_out_data_nx;
    logic               r_out_valid, w_out_valid_nx;

    logic               w_advance;
    logic               w_last;
    logic               w_in_ready;
    logic               w_xfer;
    logic               w_beat;
    logic [N-1:0]       w_oldest;
    logic [SUM_W-1:0]   w_sum_beat;

    ma_delay_line u_dline (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_beat),
        .i_wdata    (r_hold),
        .o_oldest_c (w_oldest)
    );

    assign w_advance  = !r_out_valid || bus.out_ready;
    assign w_last     = (r_phase == PHASE_W'(R - 1));
    assign w_in_ready = reset && ((r_state == IDLE) || ((r_state == RUN) && w_last && w_advance));
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_beat     = (r_state == RUN) && w_advance;
    assign w_sum_beat = r_sum + SUM_W'(r_hold) - SUM_W'(w_oldest);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;

    // Next-state: sample capture, beat issue and output-register update.
    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_hold_nx      = r_hold;
        w_sum_nx       = r_sum;
        w_out_data_nx  = r_out_data;
        w_out_valid_nx = r_out_valid;

        if (bus.out_ready) begin
            w_out_valid_nx = 1'b0;
        end

        if (r_state == IDLE) begin
            if (w_xfer) begin
                w_hold_nx  = bus.in_data;
                w_phase_nx = '0;
                w_state_nx = RUN;
            end
        end else if (w_advance) begin
            w_sum_nx       = w_sum_beat;
            w_out_data_nx  = scale_sum(w_sum_beat);
            w_out_valid_nx = 1'b1;
            if (w_last) begin
                w_phase_nx = '0;
                if (w_xfer) begin
                    w_hold_nx = bus.in_data;
                end else begin
                    w_state_nx = IDLE;
                end
            end else begin
                w_phase_nx = r_phase + PHASE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_hold      <= '0;
            r_sum       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_hold      <= w_hold_nx;
            r_sum       <= w_sum_nx;
            r_out_data  <= w_out_data_nx;
            r_out_valid <= w_out_valid_nx;
        end
    end

endmodule
